// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bundle between decode/execute (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned RAS_DEPTH  = 4
) ();
   logic                          stall;
   logic                          exc;
   logic                          branch_taken;
   logic [ADDR_WIDTH-1:0]         branch_target;
   logic                          jump;
   logic                          call;
   logic [ADDR_WIDTH-1:0]         jump_target;
   logic                          ret;
   logic [ADDR_WIDTH-1:0]         pc;
   logic [$clog2(RAS_DEPTH):0]    ras_count;
   logic                          ras_underflow;

   modport master (
      output stall, exc, branch_taken, branch_target, jump, call, jump_target, ret,
      input  pc, ras_count, ras_underflow
   );

   modport slave (
      input  stall, exc, branch_taken, branch_target, jump, call, jump_target, ret,
      output pc, ras_count, ras_underflow
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection for the fetch stage with a circular return-address stack.
module pc_sequencer #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned PC_STEP      = 1,
   parameter int unsigned RESET_VECTOR = 0,
   parameter int unsigned EXC_VECTOR   = 8,
   parameter int unsigned RAS_DEPTH    = 4
) (
   input logic          clk,
   input logic          reset,
   pc_sequencer_if.slave bus
);
   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   // One source per cycle, listed in priority order; the datapath only decodes this.
   typedef enum logic [2:0] {
      SRC_EXC, SRC_HOLD, SRC_RET, SRC_UNDER, SRC_JUMP, SRC_CALL, SRC_BRANCH, SRC_SEQ
   } src_e;

   src_e                  src;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
   logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]         top_q, top_d, top_dec;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  under_q, under_d;
   logic                  push;

   assign pc_inc  = pc_q + ADDR_WIDTH'(PC_STEP);
   assign top_dec = top_q - PW'(1);

   always_comb begin
      src = SRC_SEQ;
      if (bus.exc)
         src = SRC_EXC;
      else if (bus.stall)
         src = SRC_HOLD;
      else if (bus.ret)
         src = (cnt_q == '0) ? SRC_UNDER : SRC_RET;
      else if (bus.jump)
         src = bus.call ? SRC_CALL : SRC_JUMP;
      else if (bus.branch_taken)
         src = SRC_BRANCH;
   end

   always_comb begin
      pc_d    = pc_inc;
      top_d   = top_q;
      cnt_d   = cnt_q;
      under_d = 1'b0;
      push    = 1'b0;
      case (src)
         SRC_EXC: begin
            pc_d  = ADDR_WIDTH'(EXC_VECTOR);
            cnt_d = '0;
            top_d = '0;
         end
         SRC_HOLD:   pc_d = pc_q;
         SRC_RET: begin
            pc_d  = ras_q[top_dec];
            top_d = top_dec;
            cnt_d = cnt_q - CW'(1);
         end
         SRC_UNDER:  under_d = 1'b1;
         SRC_JUMP:   pc_d = bus.jump_target;
         SRC_CALL: begin
            // Full stack keeps counting at RAS_DEPTH; the wrapped top pointer overwrites the oldest entry.
            pc_d  = bus.jump_target;
            push  = 1'b1;
            top_d = top_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH))
               cnt_d = cnt_q + CW'(1);
         end
         SRC_BRANCH: pc_d = bus.branch_target;
         default:    pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
         top_q   <= '0;
         cnt_q   <= '0;
         under_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         top_q   <= top_d;
         cnt_q   <= cnt_d;
         under_q <= under_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push)
         ras_q[top_q] <= pc_inc;
   end

   assign bus.pc            = pc_q;
   assign bus.ras_count     = cnt_q;
   assign bus.ras_underflow = under_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed checks of pc_sequencer priority, RAS push/pop/overflow/underflow and wrap-around.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_WIDTH(16), .RAS_DEPTH(4)) bus ();

   pc_sequencer #(
      .ADDR_WIDTH(16), .PC_STEP(1), .RESET_VECTOR(0), .EXC_VECTOR(8), .RAS_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.stall = 1'b0; bus.exc = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
      bus.jump = 1'b0; bus.call = 1'b0; bus.jump_target = '0; bus.ret = 1'b0;
   endtask

   task automatic do_call(input logic [15:0] tgt);
      idle(); bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = tgt;
      step();
   endtask

   task automatic do_branch(input logic [15:0] tgt);
      idle(); bus.branch_taken = 1'b1; bus.branch_target = tgt;
      step();
   endtask

   logic [15:0] exp_ret [4];

   initial begin
      exp_ret = '{16'h51, 16'h41, 16'h31, 16'h21};
      idle();
      reset = 1'b1;
      step(); step();
      check_eq("reset_pc", bus.pc, 32'h0);
      check_eq("reset_cnt", bus.ras_count, 32'h0);
      check_eq("reset_uf", bus.ras_underflow, 32'h0);

      // sequential increment
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check_eq("seq_pc", bus.pc, 32'(i));
      end
      check_eq("seq_cnt", bus.ras_count, 32'h0);

      // stall ignores jump+call
      step();
      check_eq("pre_stall_pc", bus.pc, 32'h5);
      bus.stall = 1'b1; bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h40;
      step();
      check_eq("stall_pc", bus.pc, 32'h5);
      check_eq("stall_cnt", bus.ras_count, 32'h0);
      idle();
      step();
      check_eq("unstall_pc", bus.pc, 32'h6);

      // single call / ret
      do_branch(16'h10);
      check_eq("branch_pc", bus.pc, 32'h10);
      do_call(16'h40);
      check_eq("call_pc", bus.pc, 32'h40);
      check_eq("call_cnt", bus.ras_count, 32'h1);
      idle(); bus.ret = 1'b1;
      step();
      check_eq("ret_pc", bus.pc, 32'h11);
      check_eq("ret_cnt", bus.ras_count, 32'h0);
      check_eq("ret_uf", bus.ras_underflow, 32'h0);

      // overflow then drain, then underflow
      for (int i = 1; i <= 5; i++) begin
         do_branch(16'(i * 16));
         do_call(16'h100);
      end
      check_eq("ovf_cnt", bus.ras_count, 32'h4);
      check_eq("ovf_pc", bus.pc, 32'h100);
      for (int k = 0; k < 4; k++) begin
         idle(); bus.ret = 1'b1;
         step();
         check_eq("drain_pc", bus.pc, 32'(exp_ret[k]));
         check_eq("drain_cnt", bus.ras_count, 32'(3 - k));
      end
      step();
      check_eq("uf_pc", bus.pc, 32'h22);
      check_eq("uf_pulse", bus.ras_underflow, 32'h1);
      check_eq("uf_cnt", bus.ras_count, 32'h0);
      idle();
      step();
      check_eq("uf_after_pc", bus.pc, 32'h23);
      check_eq("uf_after", bus.ras_underflow, 32'h0);

      // exception beats stall and ret
      do_call(16'h80);
      do_call(16'h90);
      check_eq("exc_pre_cnt", bus.ras_count, 32'h2);
      idle(); bus.exc = 1'b1; bus.stall = 1'b1; bus.ret = 1'b1;
      step();
      check_eq("exc_pc", bus.pc, 32'h8);
      check_eq("exc_cnt", bus.ras_count, 32'h0);
      check_eq("exc_uf", bus.ras_underflow, 32'h0);
      idle();
      step();
      check_eq("post_exc_pc", bus.pc, 32'h9);

      // call without jump is ignored
      idle(); bus.call = 1'b1;
      step();
      check_eq("call_only_pc", bus.pc, 32'hA);
      check_eq("call_only_cnt", bus.ras_count, 32'h0);

      // ret beats jump+call
      do_call(16'h300);
      idle(); bus.ret = 1'b1; bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h400;
      step();
      check_eq("retjmp_pc", bus.pc, 32'hB);
      check_eq("retjmp_cnt", bus.ras_count, 32'h0);

      // jump beats branch
      idle(); bus.jump = 1'b1; bus.jump_target = 16'h600;
      bus.branch_taken = 1'b1; bus.branch_target = 16'h700;
      step();
      check_eq("jmp_vs_br_pc", bus.pc, 32'h600);

      // wrap-around, including the pushed return address
      do_branch(16'hFFFF);
      check_eq("wrap_pre", bus.pc, 32'hFFFF);
      idle();
      step();
      check_eq("wrap_pc", bus.pc, 32'h0);
      do_branch(16'hFFFF);
      do_call(16'h200);
      check_eq("wrap_call_cnt", bus.ras_count, 32'h1);
      idle(); bus.ret = 1'b1;
      step();
      check_eq("wrap_ret_pc", bus.pc, 32'h0);

      // reset overrides mid call sequence
      do_call(16'h500);
      do_call(16'h510);
      do_call(16'h520);
      check_eq("pre_rst_cnt", bus.ras_count, 32'h3);
      idle(); bus.jump = 1'b1; bus.call = 1'b1; bus.jump_target = 16'h530;
      reset = 1'b1;
      step();
      check_eq("rst_pc", bus.pc, 32'h0);
      check_eq("rst_cnt", bus.ras_count, 32'h0);
      reset = 1'b0;
      idle();
      step();
      check_eq("post_rst_pc", bus.pc, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
